pool_engine: RTL and testbench



---
 rtl/pool_engine.sv | 157 +++++++++++++++
 tb/tb_pool_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_engine.sv
// pool_engine: streaming 2x2 / stride-2 max or average pooling over CH
// channels in lockstep. Pixels arrive in raster order. A half-width line
// buffer holds the horizontal pair results of each even row until the
// matching odd row arrives.
module pool_engine #(
   parameter int DW      = 16,
   parameter int CH      = 32,
   parameter int IMG_MAX = 28,
   parameter int SW      = $clog2(IMG_MAX + 1)
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 start,
   input  logic                 cfg_mode,
   input  logic [SW-1:0]        cfg_width,
   input  logic [SW-1:0]        cfg_height,
   input  logic                 in_valid,
   input  logic [CH*DW-1:0]     in_data,
   output logic                 out_valid,
   output logic [CH*DW-1:0]     out_data,
   output logic                 busy,
   output logic                 done
);

   localparam int LB  = IMG_MAX / 2;
   localparam int LBW = (LB > 1) ? $clog2(LB) : 1;
   localparam logic [SW-1:0] LB_SW = SW'(LB);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t                 r_state, w_state_nxt;
   logic                   r_mode;
   logic [SW-1:0]          r_width, r_height;
   logic [SW-1:0]          r_row, r_col;
   logic signed [DW-1:0]   r_pair [CH];
   logic signed [DW:0]     r_lbuf [LB][CH];
   logic                   r_out_valid;
   logic [CH*DW-1:0]       r_out_data;

   logic                   w_acc, w_col_last, w_last, w_lok;
   logic [LBW-1:0]         w_lidx;
   logic [SW-1:0]          w_half;
   logic signed [DW-1:0]   w_px [CH];
   logic signed [DW:0]     w_hp [CH];
   logic signed [DW:0]     w_lb [CH];
   logic signed [DW-1:0]   w_vo [CH];

   // Horizontal combine: max keeps DW range, sum needs one extra bit.
   function automatic logic signed [DW:0] f_hcomb(input logic mode,
                                                  input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
      logic signed [DW:0] ax, bx;
      ax = {a[DW-1], a};
      bx = {b[DW-1], b};
      if (mode) return ax + bx;
      else      return (ax > bx) ? ax : bx;
   endfunction

   // Vertical combine: max of two pair results, or floor of 4-pixel mean.
   function automatic logic signed [DW-1:0] f_vcomb(input logic mode,
                                                    input logic signed [DW:0] a,
                                                    input logic signed [DW:0] b);
      logic signed [DW+1:0] s;
      s = {a[DW], a} + {b[DW], b};
      if (mode) return DW'(s >>> 2);
      else      return DW'((a > b) ? a : b);
   endfunction

   assign w_acc      = (r_state == S_RUN) && in_valid;
   assign w_col_last = (r_col == r_width - SW'(1));
   assign w_last     = w_col_last && (r_row == r_height - SW'(1));
   // Out-of-range widths must not index past the line buffer.
   assign w_half     = {1'b0, r_col[SW-1:1]};
   assign w_lok      = (w_half < LB_SW);
   assign w_lidx     = r_col[LBW:1];

   // Per-channel unpack and pooling arithmetic for the current beat.
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         w_px[c] = in_data[c*DW +: DW];
         w_hp[c] = f_hcomb(r_mode, r_pair[c], w_px[c]);
         w_lb[c] = w_lok ? r_lbuf[w_lidx][c] : '0;
         w_vo[c] = f_vcomb(r_mode, w_lb[c], w_hp[c]);
      end
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> FLUSH on last beat.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_acc && w_last) w_state_nxt = S_FLUSH;
         S_FLUSH: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Configuration latch and raster row/column counters.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_mode   <= 1'b0;
         r_width  <= '0;
         r_height <= '0;
         r_row    <= '0;
         r_col    <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_mode   <= cfg_mode;
         r_width  <= cfg_width;
         r_height <= cfg_height;
         r_row    <= '0;
         r_col    <= '0;
      end else if (w_acc) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= r_row + SW'(1);
         end else begin
            r_col <= r_col + SW'(1);
         end
      end
   end

   // Pair register, line buffer and registered pooled output.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         for (int c = 0; c < CH; c++) r_pair[c] <= '0;
         for (int i = 0; i < LB; i++)
            for (int c = 0; c < CH; c++) r_lbuf[i][c] <= '0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_acc) begin
            if (!r_col[0]) begin
               for (int c = 0; c < CH; c++) r_pair[c] <= w_px[c];
            end else if (!r_row[0]) begin
               if (w_lok)
                  for (int c = 0; c < CH; c++) r_lbuf[w_lidx][c] <= w_hp[c];
            end else begin
               r_out_valid <= 1'b1;
               for (int c = 0; c < CH; c++) r_out_data[c*DW +: DW] <= w_vo[c];
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_FLUSH);

endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed checks of pool_engine with hand-computed
// expected values, plus randomised-gap runs against a window model.
module tb_pool_engine;

   localparam int DW  = 16;
   localparam int CH  = 32;
   localparam int IMG = 28;
   localparam int SW  = $clog2(IMG + 1);

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic              start = 1'b0;
   logic              cfg_mode = 1'b0;
   logic [SW-1:0]     cfg_width = '0;
   logic [SW-1:0]     cfg_height = '0;
   logic              in_valid = 1'b0;
   logic [CH*DW-1:0]  in_data = '0;
   logic              out_valid;
   logic [CH*DW-1:0]  out_data;
   logic              busy;
   logic              done;

   int total = 0;
   int bad   = 0;
   int n_done = 0;
   logic [CH*DW-1:0] q_out [$];
   int pix [IMG][IMG][CH];

   int e_a [4] = '{6, 8, 14, 16};
   int e_b [4] = '{-1, -3, -9, -11};
   int e_c [4] = '{6, 8, 16, 18};
   int e_d [4] = '{16, 14, 8, 6};

   always #5 clk = ~clk;

   pool_engine #(.DW(DW), .CH(CH), .IMG_MAX(IMG), .SW(SW)) dut (
      .clk(clk), .nrst(nrst), .start(start), .cfg_mode(cfg_mode),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data),
      .busy(busy), .done(done)
   );

   // Collect results and done pulses mid-cycle.
   always @(negedge clk) begin
      if (out_valid === 1'b1) q_out.push_back(out_data);
      if (done === 1'b1) n_done++;
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [CH*DW-1:0] obs, input logic [CH*DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [CH*DW-1:0] pk(input int v0, input int v1, input int v2, input int v3);
      logic [CH*DW-1:0] r;
      r = '0;
      r[0*DW +: DW] = 16'(v0);
      r[1*DW +: DW] = 16'(v1);
      r[2*DW +: DW] = 16'(v2);
      r[3*DW +: DW] = 16'(v3);
      return r;
   endfunction

   function automatic int chv(input logic [CH*DW-1:0] v, input int c);
      logic signed [DW-1:0] t;
      t = v[c*DW +: DW];
      return int'(t);
   endfunction

   function automatic int qch(input int i, input int c);
      if (i < q_out.size()) return chv(q_out[i], c);
      return 99999;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [CH*DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic go(input logic m, input int w, input int h);
      cfg_mode   = m;
      cfg_width  = SW'(w);
      cfg_height = SW'(h);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_rand(input logic m, input int w, input int h);
      logic [CH*DW-1:0] v, e;
      int busy_bad, g, s, mx;
      q_out.delete();
      n_done = 0;
      busy_bad = 0;
      go(m, w, h);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            g = 0;
            while (($urandom_range(0, 1) == 1) && (g < 4)) begin
               tick(1);
               g++;
            end
            v = '0;
            for (int k = 0; k < CH; k++) begin
               pix[r][c][k] = int'($urandom_range(0, 65535)) - 32768;
               v[k*DW +: DW] = 16'(pix[r][c][k]);
            end
            beat(v);
            if (!((r == h - 1) && (c == w - 1)) && (busy !== 1'b1)) busy_bad++;
         end
      end
      tick(1);
      chk("rand_count", q_out.size(), (w / 2) * (h / 2));
      for (int pr = 0; pr < h / 2; pr++) begin
         for (int pc = 0; pc < w / 2; pc++) begin
            e = '0;
            for (int k = 0; k < CH; k++) begin
               s  = pix[2*pr][2*pc][k] + pix[2*pr][2*pc+1][k] + pix[2*pr+1][2*pc][k] + pix[2*pr+1][2*pc+1][k];
               mx = pix[2*pr][2*pc][k];
               if (pix[2*pr][2*pc+1][k] > mx) mx = pix[2*pr][2*pc+1][k];
               if (pix[2*pr+1][2*pc][k] > mx) mx = pix[2*pr+1][2*pc][k];
               if (pix[2*pr+1][2*pc+1][k] > mx) mx = pix[2*pr+1][2*pc+1][k];
               e[k*DW +: DW] = m ? 16'(s >>> 2) : 16'(mx);
            end
            if (pr * (w / 2) + pc < q_out.size())
               chkv("rand_result", q_out[pr * (w / 2) + pc], e);
            else
               chkv("rand_missing", 'x, e);
         end
      end
      chk("rand_done", n_done, 1);
      chk("rand_busy", busy_bad, 0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_out_valid", out_valid, 0);
      chkv("rst_out_data", out_data, '0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      #10 nrst = 1'b1;
      tick(1);

      // in_valid while IDLE is ignored
      beat(pk(99, 99, 0, 0));
      beat(pk(99, 99, 0, 0));
      tick(2);
      chk("idle_no_out", q_out.size(), 0);
      chk("idle_busy", busy, 0);

      // Max 4x4 ascending / negated
      q_out.delete(); n_done = 0;
      go(0, 4, 4);
      chk("t1_busy", busy, 1);
      for (int k = 1; k <= 16; k++) begin
         if (k == 16) chk("t1_no_early_done", done, 0);
         beat(pk(k, -k, 0, 0));
         if (k == 6) chk("t1_latency", out_valid, 1);
         if (k == 7) chk("t1_pulse", out_valid, 0);
      end
      chk("t1_done", done, 1);
      chk("t1_last_valid", out_valid, 1);
      chk("t1_busy_end", busy, 0);
      tick(1);
      chk("t1_done_pulse", done, 0);
      chk("t1_ndone", n_done, 1);
      chk("t1_count", q_out.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_ch0", qch(i, 0), e_a[i]);
         chk("t1_ch1", qch(i, 1), e_b[i]);
      end
      chk("t1_hold", chv(out_data, 0), 16);

      // Average 2x2: floor, rounding and range boundaries
      q_out.delete(); n_done = 0;
      go(1, 2, 2);
      beat(pk(-1, 7, 32767, -32768));
      beat(pk(-2, 7, 32767, -32768));
      beat(pk(-3, 7, 32767, -32768));
      beat(pk(-4, 6, 32767, -32768));
      tick(1);
      chk("t2_count", q_out.size(), 1);
      chk("t2_floor_neg", qch(0, 0), -3);
      chk("t2_floor_pos", qch(0, 1), 6);
      chk("t2_max_pos", qch(0, 2), 32767);
      chk("t2_max_neg", qch(0, 3), -32768);
      chk("t2_ndone", n_done, 1);

      // Odd 5x5 max
      q_out.delete(); n_done = 0;
      go(0, 5, 5);
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            if (r == 4 && c == 4) begin
               chk("t3_no_early_done", n_done, 0);
               chk("t3_busy", busy, 1);
            end
            beat(pk(r * 5 + c, 0, 0, 0));
         end
      end
      chk("t3_done", done, 1);
      tick(1);
      chk("t3_count", q_out.size(), 4);
      for (int i = 0; i < 4; i++) chk("t3_ch0", qch(i, 0), e_c[i]);

      // Random gaps against window model
      run_rand(1'b0, 28, 28);
      run_rand(1'b1, 7, 6);

      // Reset mid-run, then a clean run
      q_out.delete(); n_done = 0;
      go(0, 4, 4);
      for (int k = 1; k <= 10; k++) beat(pk(k, -k, 0, 0));
      chk("t5_pre_count", q_out.size(), 2);
      #2 nrst = 1'b0;
      #1;
      chk("t5_ov", out_valid, 0);
      chkv("t5_od", out_data, '0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      tick(2);
      nrst = 1'b1;
      tick(3);
      chk("t5_no_done", n_done, 0);
      q_out.delete();
      go(0, 4, 4);
      for (int k = 1; k <= 16; k++) beat(pk(17 - k, k, 0, 0));
      tick(1);
      chk("t5_count", q_out.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t5_ch0", qch(i, 0), e_d[i]);
         chk("t5_ch1", qch(i, 1), e_a[i]);
      end
      chk("t5_ndone", n_done, 1);

      // start during a run is ignored
      q_out.delete(); n_done = 0;
      go(0, 4, 4);
      for (int k = 1; k <= 16; k++) begin
         if (k == 6) begin
            start = 1'b1; cfg_width = SW'(2); cfg_height = SW'(2); cfg_mode = 1'b1;
         end
         beat(pk(k, 0, 0, 0));
         start = 1'b0;
      end
      chk("t6_done", done, 1);
      tick(1);
      chk("t6_count", q_out.size(), 4);
      for (int i = 0; i < 4; i++) chk("t6_ch0", qch(i, 0), e_a[i]);
      chk("t6_ndone", n_done, 1);

      // Back-to-back start right after done
      q_out.delete(); n_done = 0;
      go(0, 2, 2);
      beat(pk(5, 0, 0, 0));
      beat(pk(-9, 0, 0, 0));
      beat(pk(100, 0, 0, 0));
      beat(pk(3, 0, 0, 0));
      chk("t7_done", done, 1);
      tick(1);
      chk("t7_count", q_out.size(), 1);
      chk("t7_ch0", qch(0, 0), 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
